// File: rtl/cordic_gain_out_if.sv
// Stream bundle between the last CORDIC stage, the gain/FIFO block and its consumer.
// slave = gain/FIFO block side, master = upstream driver plus downstream consumer side.
interface cordic_gain_out_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     in_valid;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] y_in;
  logic signed [DATA_W-1:0] z_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] x_out;
  logic signed [DATA_W-1:0] y_out;
  logic signed [DATA_W-1:0] z_out;
  logic [CW-1:0]            fifo_count;
  logic                     overflow;

  modport slave (
    input  in_valid, x_in, y_in, z_in, out_ready,
    output out_valid, x_out, y_out, z_out, fifo_count, overflow
  );

  modport master (
    output in_valid, x_in, y_in, z_in, out_ready,
    input  out_valid, x_out, y_out, z_out, fifo_count, overflow
  );
endinterface

// File: rtl/cordic_gain_out.sv
// CORDIC gain compensation (x,y scaled by K) feeding a small valid/ready output FIFO.
// Build option: define CORDIC_GAIN_COMP_EN for the gain multiply; otherwise x/y pass through unchanged.
module cordic_gain_out #(
  parameter int                DATA_W     = 32,
  parameter int                COEF_W     = 32,
  parameter int                DEPTH      = 4,
  parameter logic [COEF_W-1:0] K_GAIN     = 32'h26DD3B6A,
  parameter int                GAIN_SHIFT = 30
) (
  input logic              clk,
  input logic              rst_n,
  cordic_gain_out_if.slave io
);

  localparam int             AW   = $clog2(DEPTH);
  localparam int             CW   = AW + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cordic_gain_out: DEPTH must be a power of two, at least 2");
  end

  // K must stay below 1.0 so the shifted product always fits back into DATA_W.
  if (GAIN_SHIFT < 1 || GAIN_SHIFT >= DATA_W + COEF_W || (K_GAIN >> GAIN_SHIFT) != 0) begin : g_bad_gain
    $error("cordic_gain_out: K_GAIN must be below 1.0 in the chosen GAIN_SHIFT format");
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int                         PROD_W  = DATA_W + COEF_W;
  localparam int                         P1_W    = PROD_W;
  localparam logic signed [PROD_W-1:0]   K_EXT   = PROD_W'(K_GAIN);
  localparam logic signed [PROD_W-1:0]   ROUND_C = PROD_W'(1) << (GAIN_SHIFT - 1);

  function automatic logic signed [PROD_W-1:0] gain_mul(input logic signed [DATA_W-1:0] a);
    return PROD_W'(a) * K_EXT;
  endfunction

  function automatic logic signed [DATA_W-1:0] round_shift(input logic signed [PROD_W-1:0] p);
    return DATA_W'((p + ROUND_C) >>> GAIN_SHIFT);
  endfunction
`else
  localparam int P1_W = DATA_W;
`endif

  logic                     vld_p1_q;
  logic signed [P1_W-1:0]   x_p1_q;
  logic signed [P1_W-1:0]   y_p1_q;
  logic signed [DATA_W-1:0] z_p1_q;

  logic signed [DATA_W-1:0] x_c_p2;
  logic signed [DATA_W-1:0] y_c_p2;

  logic signed [DATA_W-1:0] x_mem_q [DEPTH];
  logic signed [DATA_W-1:0] y_mem_q [DEPTH];
  logic signed [DATA_W-1:0] z_mem_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          pop, push, drop;

  // Stage 1: multiply (or plain capture); loaded every cycle regardless of FIFO state
  always_ff @(posedge clk) begin
`ifdef CORDIC_GAIN_COMP_EN
    x_p1_q <= gain_mul(io.x_in);
    y_p1_q <= gain_mul(io.y_in);
`else
    x_p1_q <= io.x_in;
    y_p1_q <= io.y_in;
`endif
    z_p1_q <= io.z_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= io.in_valid;
    end
  end

  // Stage 2: round and narrow; the result is the FIFO write candidate
  always_comb begin
`ifdef CORDIC_GAIN_COMP_EN
    x_c_p2 = round_shift(x_p1_q);
    y_c_p2 = round_shift(y_p1_q);
`else
    x_c_p2 = x_p1_q;
    y_c_p2 = y_p1_q;
`endif
  end

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  always_comb begin
    pop      = (cnt_q != '0) && io.out_ready;
    push     = vld_p1_q && ((cnt_q != FULL) || pop);
    drop     = vld_p1_q && (cnt_q == FULL) && !pop;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
    ovf_d    = ovf_q | drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is cleared on reset so the head reads zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        x_mem_q[i] <= '0;
        y_mem_q[i] <= '0;
        z_mem_q[i] <= '0;
      end
    end else if (push) begin
      x_mem_q[wr_ptr_q] <= x_c_p2;
      y_mem_q[wr_ptr_q] <= y_c_p2;
      z_mem_q[wr_ptr_q] <= z_p1_q;
    end
  end

  assign io.out_valid  = (cnt_q != '0);
  assign io.x_out      = x_mem_q[rd_ptr_q];
  assign io.y_out      = y_mem_q[rd_ptr_q];
  assign io.z_out      = z_mem_q[rd_ptr_q];
  assign io.fifo_count = cnt_q;
  assign io.overflow   = ovf_q;

endmodule

// File: tb/tb_cordic_gain_out.sv
// Bench for cordic_gain_out: queue-based reference model compared every cycle, plus directed scenarios.
module tb_cordic_gain_out;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } ent_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  cordic_gain_out_if #(.DATA_W(32), .DEPTH(DEPTH)) io ();

  cordic_gain_out #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected compensated value straight from the arithmetic definition.
  function automatic logic [31:0] comp(input logic [31:0] v);
`ifdef CORDIC_GAIN_COMP_EN
    longint p;
    p = longint'($signed(v)) * 64'sd652032874;
    p = (p + 64'sd536870912) >>> 30;
    return p[31:0];
`else
    return v;
`endif
  endfunction

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chkw(name, {96'd0, act}, {96'd0, exp});
  endtask

  // Reference model: one-cycle pending slot plus a bounded queue.
  ent_t mq[$];
  ent_t pend_e;
  logic pend_v;
  logic movf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      pend_v <= 1'b0;
      movf   <= 1'b0;
    end else begin
      if ((mq.size() != 0) && io.out_ready) void'(mq.pop_front());
      if (pend_v) begin
        if (mq.size() < DEPTH) mq.push_back(pend_e);
        else movf <= 1'b1;
      end
      pend_v <= io.in_valid;
      pend_e <= {comp(io.x_in), comp(io.y_in), io.z_in};
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chkw("cycle_status",
           {96'd0, 27'd0, io.out_valid, io.overflow, io.fifo_count},
           {96'd0, 27'd0, (mq.size() != 0), movf, 3'(mq.size())});
      if (mq.size() != 0)
        chkw("cycle_head", {32'd0, io.x_out, io.y_out, io.z_out}, {32'd0, mq[0]});
    end
  end

  task automatic cyc(input logic v, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] z, input logic r);
    io.in_valid  = v;
    io.x_in      = x;
    io.y_in      = y;
    io.z_in      = z;
    io.out_ready = r;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, io.out_valid}, 32'd0);
    chk("rst_count", {29'd0, io.fifo_count}, 32'd0);
    chk("rst_ovf",   {31'd0, io.overflow}, 32'd0);
    chk("rst_xout",  io.x_out, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [31:0] sp [5];
  logic [31:0] rx, ry, rz;
  logic [31:0] exp_bx, exp_by;

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    io.in_valid = 1'b0;
    io.x_in = '0;
    io.y_in = '0;
    io.z_in = '0;
    io.out_ready = 1'b0;
    sp[0] = 32'h00000000; sp[1] = 32'h00000001; sp[2] = 32'hFFFFFFFF;
    sp[3] = 32'h7FFFFFFF; sp[4] = 32'h80000000;

`ifdef CORDIC_GAIN_COMP_EN
    exp_bx = 32'h26DD3B6A;
    exp_by = 32'hD922C496;
    chk("pin_pos", comp(32'h40000000), 32'h26DD3B6A);
    chk("pin_neg", comp(32'hC0000000), 32'hD922C496);
    chk("pin_one", comp(32'h00000001), 32'h00000001);
    chk("pin_m1",  comp(32'hFFFFFFFF), 32'hFFFFFFFF);
    chk("pin_3",   comp(32'h00000003), 32'h00000002);
`else
    exp_bx = 32'h40000000;
    exp_by = 32'hC0000000;
    chk("pin_pos", comp(32'h40000000), 32'h40000000);
    chk("pin_m1",  comp(32'hFFFFFFFF), 32'hFFFFFFFF);
`endif

    repeat (3) @(negedge clk);
    chk("init_valid", {31'd0, io.out_valid}, 32'd0);
    chk("init_count", {29'd0, io.fifo_count}, 32'd0);
    chk("init_ovf",   {31'd0, io.overflow}, 32'd0);
    chk("init_xout",  io.x_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic gain, two-cycle latency, held for one cycle
    cyc(1'b1, 32'h40000000, 32'hC0000000, 32'h00001234, 1'b1);
    chk("basic_early", {31'd0, io.out_valid}, 32'd0);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("basic_valid", {31'd0, io.out_valid}, 32'd1);
    chk("basic_x", io.x_out, exp_bx);
    chk("basic_y", io.y_out, exp_by);
    chk("basic_z", io.z_out, 32'h00001234);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("basic_gone", {31'd0, io.out_valid}, 32'd0);

    // rounding edges back to back
    cyc(1'b1, 32'h00000001, 32'd0, 32'd1, 1'b1);
    cyc(1'b1, 32'hFFFFFFFF, 32'd0, 32'd2, 1'b1);
    chk("rnd_p1", io.x_out, 32'h00000001);
    cyc(1'b1, 32'h00000000, 32'd0, 32'd3, 1'b1);
    chk("rnd_m1", io.x_out, 32'hFFFFFFFF);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("rnd_zero", io.x_out, 32'h00000000);
    chk("rnd_zero_v", {31'd0, io.out_valid}, 32'd1);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("rnd_empty", {31'd0, io.out_valid}, 32'd0);

    // fill and overflow
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, 32'(i), 32'(i), 32'(i), 1'b0);
      if (i == 5) begin
        chk("fill_count", {29'd0, io.fifo_count}, 32'd4);
        chk("fill_ovf_pre", {31'd0, io.overflow}, 32'd0);
      end
    end
    chk("fill_ovf", {31'd0, io.overflow}, 32'd1);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk("fill_pop", io.x_out, comp(32'(i)));
      chk("fill_pop_z", io.z_out, 32'(i));
      cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    end
    chk("fill_drained", {31'd0, io.out_valid}, 32'd0);
    chk("fill_ovf_sticky", {31'd0, io.overflow}, 32'd1);
    pulse_reset();

    // full with simultaneous pop
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'(100 + i), 32'(i), 32'(100 + i), 1'b0);
    chk("fp_full", {29'd0, io.fifo_count}, 32'd4);
    for (int i = 5; i < 13; i++) begin
      cyc(1'b1, 32'(100 + i), 32'(i), 32'(100 + i), 1'b1);
      chk("fp_count", {29'd0, io.fifo_count}, 32'd4);
      chk("fp_ovf", {31'd0, io.overflow}, 32'd0);
    end
    repeat (6) cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("fp_drained", {31'd0, io.out_valid}, 32'd0);

    // reset mid-stream
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(200 + i), 32'd0, 32'(200 + i), 1'b0);
    chk("ms_count", {29'd0, io.fifo_count}, 32'd3);
    io.in_valid = 1'b0;
    pulse_reset();
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("ms_none1", {31'd0, io.out_valid}, 32'd0);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("ms_none2", {31'd0, io.out_valid}, 32'd0);
    cyc(1'b1, 32'h40000000, 32'hC0000000, 32'h00000055, 1'b0);
    chk("ms_new_early", {31'd0, io.out_valid}, 32'd0);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("ms_new_valid", {31'd0, io.out_valid}, 32'd1);
    chk("ms_new_x", io.x_out, exp_bx);
    chk("ms_new_z", io.z_out, 32'h00000055);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

    // randomized traffic; the second half starves the consumer to force drops
    for (int n = 0; n < 700; n++) begin
      rx = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom();
      ry = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom();
      rz = $urandom();
      cyc($urandom_range(0, 3) != 0, rx, ry, rz,
          (n < 400) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0));
    end
    repeat (8) cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("end_empty", {31'd0, io.out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cordic_gain_out.md
Name: cordic_gain_out

Overview:
- Downstream consumer of the final CORDIC shift-accumulate stage.
- Applies CORDIC gain compensation to the x/y results: multiply by K ≈ 0.6072529350, with round-half-up and arithmetic shift. z (residual angle) passes through unchanged.
- Absorbs the free-running, never-stalling pipeline output in a small FIFO and presents it on a valid/ready interface to the consumer.
- Overflow is flagged and held sticky, never silently ignored.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- K_GAIN, 32'h26DD3B6A, gain constant in unsigned Q2.30 (round(0.6072529350·2^30) = 652032874).
- GAIN_SHIFT, 30, right-shift applied to the 64-bit product.

Ports:
- clk  in  1  rising-edge clock, shared with the pipeline stages.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  final-stage result valid this cycle; no back-pressure to upstream.
- x_in  in  32  signed x from the last stage.
- y_in  in  32  signed y from the last stage.
- z_in  in  32  signed residual angle.
- out_valid  out  1  FIFO head holds data.
- out_ready  in  1  consumer accepts the head this cycle.
- x_out  out  32  compensated x at the FIFO head.
- y_out  out  32  compensated y at the FIFO head.
- z_out  out  32  z at the FIFO head.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.

Behaviour:
- Reset: rst_n low clears, asynchronously, the stage-1 valid, the FIFO pointers, fifo_count, overflow and out_valid.
  - x_out, y_out and z_out read 0 during reset (FIFO storage cleared).
  - Reset mid-operation discards every in-flight and buffered result. The first in_valid after release behaves as from idle.
- Stage 1 (edge k, when in_valid=1):
  - p_x = $signed(x_in) × $signed({1'b0,K_GAIN}), 64-bit signed; p_y computed the same way from y_in.
  - z_in registered unchanged; v1 <= in_valid.
  - Stage 1 is loaded every cycle, independent of FIFO state.
- Stage 2 (edge k+1, when v1=1):
  - x_c = (p_x + 2^(GAIN_SHIFT-1)) >>> GAIN_SHIFT, truncated to 32 bits; y_c computed the same way.
  - Because |K| < 1, the truncation never loses significance.
  - {x_c, y_c, z} is the write candidate to the FIFO.
- Latency: in_valid sampled at edge k gives out_valid=1 after edge k+1 (2 cycles) when the FIFO was empty. Throughput is 1 result per cycle.
- FIFO:
  - Circular buffer, separate read and write pointers wrapping modulo DEPTH.
  - fifo_count is tracked explicitly (0..DEPTH).
  - Outputs come combinationally from the head entry.
  - out_valid = (fifo_count != 0).
- Pop: out_valid && out_ready at an edge advances the read pointer.
  - out_ready while empty has no effect.
- Push: the v1 candidate is written when fifo_count < DEPTH, or when fifo_count == DEPTH and a pop occurs in the same cycle (full with simultaneous pop: accept, count stays DEPTH).
- Drop: v1=1, full and no pop. The candidate is discarded, FIFO contents are untouched, overflow <= 1.
  - overflow stays 1 until reset.
- Simultaneous push and pop at any non-empty level: count unchanged, both pointers advance.
- Head stability: while out_valid=1 and out_ready=0, x_out/y_out/z_out hold stable.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined: gain multiplication and rounding as described above.
- Undefined:
  - No multiplier is inferred; x and y pass through stages 1 and 2 as plain registers (x_c = x_in, y_c = y_in).
  - Latency, FIFO, handshake and overflow behaviour are identical.
  - K_GAIN and GAIN_SHIFT are ignored.

Test Plan:
- Basic gain (macro on): x_in=32'h40000000, y_in=32'hC0000000, z_in=32'h00001234, out_ready=1 → two cycles later out_valid=1, x_out=32'h26DD3B6A, y_out=32'hD922C496, z_out=32'h00001234, held for one cycle.
- Rounding edges: x_in = 1, -1, 0 on consecutive cycles, out_ready=1 → x_out = 1, 32'hFFFFFFFF, 0 in order, with no gaps.
- Fill/overflow (DEPTH=4): out_ready=0, six back-to-back in_valid carrying x_in=1..6 → fifo_count=4, overflow=1 from the edge that drops item 5. Then out_ready=1 → pops items 1..4 in order, and overflow stays 1.
- Full with simultaneous pop: FIFO full, out_ready=1 and in_valid streaming → no drop, overflow stays 0, fifo_count stays 4, output order preserved.
- Reset mid-stream: 3 entries buffered plus 1 in stage 1, rst_n pulsed low for less than one cycle asynchronously → out_valid=0, fifo_count=0 and overflow=0 immediately. Nothing is emitted from the pre-reset data, and a new input appears 2 cycles after its in_valid.
- Macro off: x_in=32'h40000000 → x_out=32'h40000000 after 2 cycles, with the same FIFO behaviour.
